// File: rtl/nvdla_package.sv
// Shared types and constants for the DBB initiator.
package nvdla_package;

  localparam int WORD_W       = 32;
  localparam int MEMIF_W_DFLT = 512;

  // Words of WORD_W bits carried by one DBB beat of width w.
  function automatic int dbb_ratio(input int w);
    return w / WORD_W;
  endfunction

  localparam int RATIO = MEMIF_W_DFLT / WORD_W;

  typedef enum logic [2:0] {
    IDLE, REQ, WPACK, WBEAT, WRSP, RBEAT, RUNPACK, DONE
  } state_dbb_init_t;

  // Latched command; the id is held separately since its width is a module parameter.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [7:0]  len;
  } ctrl_dbb_init_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic error;
  } flags_dbb_init_t;

endpackage

// File: rtl/nvdla_dbb_word_packer.sv
// Beat-wide slot register: filled word by word when packing writes,
// loaded with a whole beat and read word by word when unpacking reads.
module nvdla_dbb_word_packer
  import nvdla_package::*;
#(
  parameter int MEMIF_W = 512,
  parameter int SW      = 4
)(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic                 ld_i,
  input  logic [SW-1:0]        slot_i,
  input  logic [WORD_W-1:0]    word_i,
  input  logic [3:0]           wstrb_i,
  input  logic [MEMIF_W-1:0]   beat_i,
  output logic [MEMIF_W-1:0]   beat_o,
  output logic [MEMIF_W/8-1:0] strb_o,
  output logic [WORD_W-1:0]    word_o
);

  logic [MEMIF_W-1:0]   r_data;
  logic [MEMIF_W/8-1:0] r_strb;

  // Whole-beat load takes priority; otherwise a single slot is written.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
      r_strb <= '0;
    end else if (ld_i) begin
      r_data <= beat_i;
      r_strb <= '1;
    end else if (wr_i) begin
      r_data[WORD_W*int'(slot_i) +: WORD_W] <= word_i;
      r_strb[4*int'(slot_i) +: 4]           <= wstrb_i;
    end
  end

  assign beat_o = r_data;
  assign strb_o = r_strb;
  assign word_o = r_data[WORD_W*int'(slot_i) +: WORD_W];

endmodule

// File: rtl/nvdla_dbb_initiator.sv
// DBB master: turns a start command into one DBB request and moves
// 32-bit stream words to/from MEMIF_W-wide DBB beats.
module nvdla_dbb_initiator
  import nvdla_package::*;
#(
  parameter int MEMIF_W = MEMIF_W_DFLT,
  parameter int ID_W    = 8
)(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  // command / status
  input  logic                 start_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [7:0]           len_i,
  input  logic [ID_W-1:0]      id_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  // write word stream (sink)
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [31:0]          wdata_data_i,
  input  logic [3:0]           wdata_strb_i,
  // read word stream (source)
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [31:0]          rdata_data_o,
  output logic [3:0]           rdata_strb_o,
  // DBB request
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 req_write_o,
  output logic [31:0]          req_addr_o,
  output logic [7:0]           req_len_o,
  output logic [ID_W-1:0]      req_id_o,
  // DBB write data
  output logic                 wdat_valid_o,
  input  logic                 wdat_ready_i,
  output logic [MEMIF_W-1:0]   wdat_data_o,
  output logic [MEMIF_W/8-1:0] wdat_strb_o,
  output logic                 wdat_last_o,
  // DBB write response
  input  logic                 wrsp_valid_i,
  output logic                 wrsp_ready_o,
  input  logic [ID_W-1:0]      wrsp_id_i,
  // DBB read data
  input  logic                 rdat_valid_i,
  output logic                 rdat_ready_o,
  input  logic [MEMIF_W-1:0]   rdat_data_i,
  input  logic [ID_W-1:0]      rdat_id_i,
  input  logic                 rdat_last_i
);

  localparam int NW = dbb_ratio(MEMIF_W);
  localparam int SW = (NW > 1) ? $clog2(NW) : 1;

  state_dbb_init_t r_state, w_next;
  ctrl_dbb_init_t  r_ctrl;
  flags_dbb_init_t w_flags;
  logic [ID_W-1:0] r_id;
  logic [SW-1:0]   r_word_cnt;
  logic [7:0]      r_beat_cnt;
  logic            r_err;

  logic            w_soft_rst, w_last_beat, w_last_slot, w_pk_wr, w_pk_ld;
  logic [MEMIF_W-1:0]   w_pk_beat;
  logic [MEMIF_W/8-1:0] w_pk_strb;
  logic [31:0]          w_pk_word;

  assign w_soft_rst  = rst_i | clear_i;
  assign w_last_beat = (r_beat_cnt == 8'(r_ctrl.len - 8'd1));
  assign w_last_slot = (r_word_cnt == SW'(NW - 1));
  assign w_pk_wr     = (r_state == WPACK) & wdata_valid_i;
  assign w_pk_ld     = (r_state == RBEAT) & rdat_valid_i;

  nvdla_dbb_word_packer #(.MEMIF_W(MEMIF_W), .SW(SW)) u_packer (
    .clk_i   (clk_i),
    .rst_i   (w_soft_rst),
    .wr_i    (w_pk_wr),
    .ld_i    (w_pk_ld),
    .slot_i  (r_word_cnt),
    .word_i  (wdata_data_i),
    .wstrb_i (wdata_strb_i),
    .beat_i  (rdat_data_i),
    .beat_o  (w_pk_beat),
    .strb_o  (w_pk_strb),
    .word_o  (w_pk_word)
  );

  // State, latched command, counters and sticky error.
  always_ff @(posedge clk_i) begin
    if (w_soft_rst) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_id       <= '0;
      r_word_cnt <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (start_i) begin
          r_ctrl     <= '{write: write_i, addr: addr_i, len: len_i};
          r_id       <= id_i;
          r_err      <= (len_i == 8'd0);
          r_word_cnt <= '0;
          r_beat_cnt <= '0;
        end
        WPACK: if (wdata_valid_i)
          r_word_cnt <= w_last_slot ? '0 : r_word_cnt + SW'(1);
        WBEAT: if (wdat_ready_i)
          r_beat_cnt <= r_beat_cnt + 8'd1;
        WRSP: if (wrsp_valid_i && (wrsp_id_i != r_id))
          r_err <= 1'b1;
        RBEAT: if (rdat_valid_i && ((rdat_id_i != r_id) || (rdat_last_i != w_last_beat)))
          r_err <= 1'b1;
        RUNPACK: if (rdata_ready_i) begin
          r_word_cnt <= w_last_slot ? '0 : r_word_cnt + SW'(1);
          if (w_last_slot) r_beat_cnt <= r_beat_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next state and handshake strobes; everything idle by default.
  always_comb begin
    w_next        = r_state;
    req_valid_o   = 1'b0;
    wdata_ready_o = 1'b0;
    wdat_valid_o  = 1'b0;
    wrsp_ready_o  = 1'b0;
    rdat_ready_o  = 1'b0;
    rdata_valid_o = 1'b0;
    case (r_state)
      IDLE:    if (start_i) w_next = (len_i == 8'd0) ? DONE : REQ;
      REQ: begin
        req_valid_o = 1'b1;
        if (req_ready_i) w_next = r_ctrl.write ? WPACK : RBEAT;
      end
      WPACK: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i && w_last_slot) w_next = WBEAT;
      end
      WBEAT: begin
        wdat_valid_o = 1'b1;
        if (wdat_ready_i) w_next = w_last_beat ? WRSP : WPACK;
      end
      WRSP: begin
        wrsp_ready_o = 1'b1;
        if (wrsp_valid_i) w_next = DONE;
      end
      RBEAT: begin
        rdat_ready_o = 1'b1;
        if (rdat_valid_i) w_next = RUNPACK;
      end
      RUNPACK: begin
        rdata_valid_o = 1'b1;
        if (rdata_ready_i && w_last_slot) w_next = w_last_beat ? DONE : RBEAT;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_flags = '{busy: (r_state != IDLE), done: (r_state == DONE), error: r_err};
  assign busy_o  = w_flags.busy;
  assign done_o  = w_flags.done;
  assign error_o = w_flags.error;

  assign req_write_o  = r_ctrl.write;
  assign req_addr_o   = r_ctrl.addr;
  assign req_len_o    = r_ctrl.len;
  assign req_id_o     = r_id;
  assign wdat_data_o  = w_pk_beat;
  assign wdat_strb_o  = w_pk_strb;
  assign wdat_last_o  = w_last_beat;
  assign rdata_data_o = w_pk_word;
  assign rdata_strb_o = 4'hF;

endmodule
